// File: rtl/core_pkg.sv
// Shared definitions for the RV32 fetch stage: FSM encoding and architectural constants.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pc_next.sv
// Next-PC adder: sequential step or signed branch offset, modulo 2^32.
// With FETCH_MISALIGN_TRAP_EN defined it also flags a non-word-aligned result.
module pc_next
  import core_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pcbr,
  output logic [31:0] next_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  // A zero offset from the branch unit means "not taken", so fall through.
  assign next_pc = pc + ((pcbr != 32'd0) ? pcbr : PC_STEP);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = |next_pc[1:0];
`endif

endmodule

// File: rtl/instruction_fetch.sv
// RV32 instruction fetch stage: owns the PC, fetches over req/ack, holds oIR until execute completes.
// Optional FETCH_MISALIGN_TRAP_EN halts fetch when the next PC is not word aligned.
module instruction_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oIMEM_REQ,
  output logic [31:0] oIMEM_ADDR,
  input  logic        iIMEM_ACK,
  input  logic [31:0] iIMEM_DATA,
  output logic [31:0] oIR,
  output logic        oIR_VALID,
  input  logic        iEX_DONE,
  input  logic [31:0] iPCBR,
  output logic [31:0] oPC,
  output logic        oHALT
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic         ir_valid_q, ir_valid_d;
  logic [31:0]  next_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic         misaligned;

  pc_next u_pc_next (
    .pc         (pc_q),
    .pcbr       (iPCBR),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );
`else
  pc_next u_pc_next (
    .pc      (pc_q),
    .pcbr    (iPCBR),
    .next_pc (next_pc)
  );
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INSN;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (iIMEM_ACK) begin
          ir_d       = iIMEM_DATA;
          ir_valid_d = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (iEX_DONE) begin
          pc_d       = next_pc;
          ir_valid_d = 1'b0;
          state_d    = FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (misaligned) state_d = HALT;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      HALT: state_d = HALT;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Request is a pure state decode so memory never sees a combinational loop through ack.
  assign oIMEM_REQ  = (state_q == FETCH);
  assign oIMEM_ADDR = pc_q;
  assign oPC        = pc_q;
  assign oIR        = ir_q;
  assign oIR_VALID  = ir_valid_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign oHALT = (state_q == HALT);
`else
  assign oHALT = 1'b0;
`endif

endmodule
